// File: rtl/seg7_page_sched.sv
// rtl/seg7_page_sched.sv - round-robin scheduler of requester pages onto six seven-segment digits
module seg7_page_sched #(
  parameter int NSRC  = 4,
  parameter int DWELL = 50_000_000,
  parameter int DEB   = 1_000_000,
  localparam int PW   = $clog2(NSRC)
) (
  input  logic                 max10_clk1_50,
  input  logic                 reset,
  input  logic [NSRC*24-1:0]   src_data,
  input  logic [NSRC-1:0]      src_valid,
  input  logic                 key_n,
  input  logic                 hold,
  output logic [7:0]           hex0,
  output logic [7:0]           hex1,
  output logic [7:0]           hex2,
  output logic [7:0]           hex3,
  output logic [7:0]           hex4,
  output logic [7:0]           hex5,
  output logic [PW-1:0]        page,
  output logic [NSRC-1:0]      page_ack
);

  localparam int DW = $clog2(DWELL);
  localparam int CW = $clog2(DEB);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   page_nx, cand, lowest;
  logic [DW-1:0]   dwell, dwell_nx;
  logic [NSRC-1:0] ack_nx;
  logic            found;
  logic            key_s1, key_s2, key_level, press;
  logic [CW-1:0]   deb_cnt;
  logic [23:0]     src_arr [NSRC];
  logic [23:0]     cur;
  logic [7:0]      hex_q [6];

  function automatic logic [7:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 8'hC0;  4'h1: enc = 8'hF9;  4'h2: enc = 8'hA4;  4'h3: enc = 8'hB0;
      4'h4: enc = 8'h99;  4'h5: enc = 8'h92;  4'h6: enc = 8'h82;  4'h7: enc = 8'hF8;
      4'h8: enc = 8'h80;  4'h9: enc = 8'h90;  4'hA: enc = 8'h88;  4'hB: enc = 8'h83;
      4'hC: enc = 8'hC6;  4'hD: enc = 8'hA1;  4'hE: enc = 8'h86;  default: enc = 8'h8E;
    endcase
  endfunction

  // Level only moves after DEB consecutive synchronised samples disagree with it.
  always_ff @(posedge max10_clk1_50 or posedge reset) begin
    if (reset) begin
      key_s1    <= 1'b1;
      key_s2    <= 1'b1;
      key_level <= 1'b1;
      deb_cnt   <= '0;
      press     <= 1'b0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      press  <= 1'b0;
      if (key_s2 == key_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        key_level <= key_s2;
        deb_cnt   <= '0;
        press     <= ~key_s2;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    cand   = page;
    found  = 1'b0;
    lowest = '0;
    for (int k = 1; k <= NSRC; k++) begin
      if (!found && src_valid[PW'((int'(page) + k) % NSRC)]) begin
        cand  = PW'((int'(page) + k) % NSRC);
        found = 1'b1;
      end
    end
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_valid[i]) lowest = PW'(i);
    end
  end

  always_comb begin
    state_nx = state;
    page_nx  = page;
    dwell_nx = dwell;
    ack_nx   = '0;
    case (state)
      IDLE: begin
        if (|src_valid) begin
          state_nx       = SHOW;
          page_nx        = lowest;
          dwell_nx       = '0;
          ack_nx[lowest] = 1'b1;
        end
      end
      SHOW: begin
        if (!(|src_valid)) begin
          state_nx = IDLE;
        end else if (!src_valid[page] || press || (dwell == DWELL_LAST && !hold)) begin
          page_nx  = cand;
          dwell_nx = '0;
          if (cand != page) ack_nx[cand] = 1'b1;
        end else if (!hold) begin
          dwell_nx = dwell + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge max10_clk1_50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      page     <= '0;
      dwell    <= '0;
      page_ack <= '0;
    end else begin
      state    <= state_nx;
      page     <= page_nx;
      dwell    <= dwell_nx;
      page_ack <= ack_nx;
    end
  end

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    assign src_arr[g] = src_data[24*g +: 24];
  end
  assign cur = src_arr[page];

  // Display follows the registered page, so it trails a page switch by one cycle.
  always_ff @(posedge max10_clk1_50 or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 6; k++) hex_q[k] <= 8'hBF;
    end else begin
      for (int k = 0; k < 6; k++) hex_q[k] <= (state == SHOW) ? enc(cur[4*k +: 4]) : 8'hBF;
      if (state == SHOW && hold) hex_q[0][7] <= 1'b0;
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

endmodule

// File: tb/tb_seg7_page_sched.sv
// tb/tb_seg7_page_sched.sv - directed and random checks of seg7_page_sched against a page-level model
module tb_seg7_page_sched;
  localparam int NSRC = 4, DWELL = 10, DEB = 3;

  logic        clk = 1'b0;
  logic        reset, key_n, hold;
  logic [95:0] src_data;
  logic [3:0]  src_valid;
  logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [1:0]  page;
  logic [3:0]  page_ack;
  logic [7:0]  dut_hex [6];

  always #10 clk = ~clk;

  seg7_page_sched #(.NSRC(NSRC), .DWELL(DWELL), .DEB(DEB)) dut (
    .max10_clk1_50(clk), .reset(reset), .src_data(src_data), .src_valid(src_valid),
    .key_n(key_n), .hold(hold), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .hex4(hex4), .hex5(hex5), .page(page), .page_ack(page_ack)
  );

  assign dut_hex[0] = hex0;
  assign dut_hex[1] = hex1;
  assign dut_hex[2] = hex2;
  assign dut_hex[3] = hex3;
  assign dut_hex[4] = hex4;
  assign dut_hex[5] = hex5;

  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  bit         m_active, m_level, m_press, m_sync0, m_sync1;
  int         m_page, m_dwell;
  logic [3:0] m_ack;
  logic [7:0] m_hex [6];
  bit         hist [$];

  function automatic int next_valid(input int p, input logic [3:0] v);
    for (int k = 1; k <= NSRC; k++)
      if (v[(p + k) % NSRC]) return (p + k) % NSRC;
    return p;
  endfunction

  function automatic int lowest_valid(input logic [3:0] v);
    for (int i = 0; i < NSRC; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_active = 0; m_page = 0; m_dwell = 0; m_ack = '0;
    m_level = 1; m_press = 0; m_sync0 = 1; m_sync1 = 1;
    hist.delete();
    for (int k = 0; k < 6; k++) m_hex[k] = 8'hBF;
  endtask

  task automatic model_step();
    logic [23:0] d;
    logic [7:0]  nh [6];
    bit          s2, same, np;
    int          c;
    d = src_data[24*m_page +: 24];
    for (int k = 0; k < 6; k++) nh[k] = m_active ? seg_tbl[d[4*k +: 4]] : 8'hBF;
    if (m_active && hold) nh[0][7] = 1'b0;
    m_ack = '0;
    if (!m_active) begin
      if (src_valid != 0) begin
        m_active = 1; m_page = lowest_valid(src_valid); m_dwell = 0; m_ack[m_page] = 1'b1;
      end
    end else if (src_valid == 0) begin
      m_active = 0;
    end else if (!src_valid[m_page] || m_press || (m_dwell == DWELL - 1 && !hold)) begin
      c = next_valid(m_page, src_valid);
      if (c != m_page) m_ack[c] = 1'b1;
      m_page = c; m_dwell = 0;
    end else if (!hold) begin
      m_dwell++;
    end
    s2 = m_sync1;
    hist.push_back(s2);
    if (hist.size() > DEB) void'(hist.pop_front());
    np = 0;
    if (hist.size() == DEB) begin
      same = 1;
      foreach (hist[i]) if (hist[i] != s2) same = 0;
      if (same && s2 != m_level) begin
        m_level = s2;
        np = (s2 == 0);
      end
    end
    m_press = np;
    m_sync1 = m_sync0;
    m_sync0 = key_n;
    m_hex = nh;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset(); else model_step();
    @(negedge clk);
    check("page", page, m_page);
    check("page_ack", page_ack, m_ack);
    for (int k = 0; k < 6; k++) check($sformatf("hex%0d", k), dut_hex[k], m_hex[k]);
  endtask

  int p0, key_left;

  initial begin
    reset = 1; key_n = 1; hold = 0; src_valid = '0; src_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_page", page, 0);
    check("rst_ack", page_ack, 0);
    for (int k = 0; k < 6; k++) check($sformatf("rst_hex%0d", k), dut_hex[k], 8'hBF);
    reset = 0;
    repeat (3) tick();

    src_data  = {24'h0, 24'hABCDEF, 24'h0, 24'h012345};
    src_valid = 4'b0101;
    tick();
    check("first_ack", page_ack, 4'b0001);
    tick();
    check("p0_hex5", hex5, 8'hC0);
    check("p0_hex0", hex0, 8'h92);
    repeat (9) tick();
    check("dwell_page2", page, 2);
    check("dwell_ack2", page_ack, 4'b0100);
    tick();
    check("p2_hex5", hex5, 8'h88);
    check("p2_hex0", hex0, 8'h8E);
    repeat (9) tick();
    check("wrap_page0", page, 0);

    hold = 1;
    repeat (40) tick();
    check("hold_page", page, 0);
    check("hold_dp", hex0, 8'h12);
    key_n = 0; repeat (2) tick(); key_n = 1;
    repeat (8) tick();
    check("glitch_page", page, 0);
    key_n = 0; repeat (5) tick(); key_n = 1;
    repeat (8) tick();
    check("press_page", page, 2);
    hold = 0;

    for (int i = 0; i < 20 && m_dwell != 4; i++) tick();
    src_valid = 4'b0001;
    tick();
    check("drop_page", page, 0);
    check("drop_ack", page_ack, 4'b0001);
    src_valid = 4'b0000;
    repeat (2) tick();
    check("idle_hex0", hex0, 8'hBF);

    src_valid = 4'b0010;
    repeat (26) tick();
    check("single_page", page, 1);

    src_valid = 4'b1111;
    tick();
    for (int i = 0; i < 20 && m_dwell != 4; i++) tick();
    p0 = m_page;
    key_n = 0; repeat (5) tick(); key_n = 1;
    tick();
    check("coinc_page", page, (p0 + 1) % NSRC);
    check("coinc_ack", page_ack, 4'b0001 << ((p0 + 1) % NSRC));
    tick();
    check("coinc_ack_clear", page_ack, 0);
    repeat (3) tick();
    #3 reset = 1;
    #1;
    check("async_page", page, 0);
    check("async_ack", page_ack, 0);
    check("async_hex0", hex0, 8'hBF);
    check("async_hex5", hex5, 8'hBF);
    model_reset();
    tick();
    reset = 0;

    key_left = 0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom % 20 == 0) src_valid = 4'($urandom);
      if ($urandom % 8 == 0) src_data = {$urandom, $urandom, $urandom};
      if ($urandom % 40 == 0) hold = ~hold;
      if (key_left == 0) begin
        key_n = ~key_n;
        key_left = $urandom_range(1, 6);
      end
      key_left--;
      reset = ($urandom % 300 == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seg7_page_sched.md
Name: seg7_page_sched

Overview:
- Schedules the six seven-segment digits (hex0..hex5 into pin_ip) among NSRC requesters, each offering a 24-bit value (six hex nibbles).
- Rotates round-robin through the valid requesters every DWELL cycles, encodes the nibbles to active-low segment patterns, and supports two controls: manual advance from a debounced pushbutton, and hold from a switch.
- Sits between user design blocks and the pin_ip seg7 inputs, and replaces the tie-to-8'hFF assignments.

Parameters:
NSRC, 4, number of requesters (2..8); PW = clog2(NSRC)
DWELL, 50_000_000, cycles each page is shown (1 s at 50 MHz); minimum 2
DEB, 1_000_000, cycles key_n must be stable to register a change (20 ms); minimum 2

Ports:
max10_clk1_50  in   1         system clock, 50 MHz
reset          in   1         asynchronous, active-high
src_data       in   NSRC*24   requester i value at bits [24i+23:24i]; nibble 5 (MSB) goes to hex5
src_valid      in   NSRC      requester i has a page to show; level signal
key_n          in   1         raw pushbutton, active-low, asynchronous to clock
hold           in   1         switch; 1 freezes the dwell timer
hex0..hex5     out  8 each    active-low segments {dp,g,f,e,d,c,b,a}
page           out  PW        index of the requester currently shown
page_ack       out  NSRC      one-cycle pulse on bit i when the display switches to requester i

Behaviour:
- Reset (asynchronous, immediate) sets:
  - state=IDLE, page=0, page_ack=0, dwell counter=0.
  - Debouncer: synchronised and debounced key level = 1 (released).
  - hex0..hex5 = 8'hBF (dash).
- Key path:
  - 2-flop synchroniser, then a stability counter.
  - The debounced level updates only after DEB consecutive equal synchronised samples.
  - A 1->0 transition of the debounced level produces a one-cycle press event.
  - Glitches shorter than DEB cycles produce no event.
- Next-candidate search is combinational: the first index with src_valid set, scanning page+1, page+2, ... with wrap-around, ending at page itself.
- States:
  - IDLE: if any src_valid bit is set, load page = lowest valid index, pulse page_ack[page], clear dwell, go to SHOW. Otherwise hex = dashes.
  - SHOW, no valid bits: go to IDLE next edge. No ack; hex = dashes one cycle later.
  - SHOW, src_valid[page]=0 but another bit set: advance to the candidate next edge.
  - SHOW, press event: advance.
  - SHOW, dwell == DWELL-1 and hold=0: advance.
  - SHOW, hold=1: dwell counter frozen. Press events still advance.
- Advance:
  - Load page = candidate and clear dwell.
  - Pulse page_ack[candidate] in the same edge page updates.
  - If the candidate equals the current page (only one valid source), page is unchanged, no ack, and dwell restarts.
  - A press event and a dwell expiry in the same cycle produce exactly one advance.
- Display latency:
  - hex is registered as hexK = enc(src_data[page] nibble K), one cycle after page or src_data changes.
  - Live data: src_data changes during SHOW propagate with one-cycle latency.
- Encoding for nibbles 0..F, bit7 = 1:
  - 0..7 = C0, F9, A4, B0, 99, 92, 82, F8
  - 8..F = 80, 90, 88, 83, C6, A1, 86, 8E
- Decimal points:
  - hex0 dp (bit7) = 0 while hold=1 in SHOW.
  - All other dp bits = 1.
  - All dp bits = 1 in IDLE.
- page_ack is never multi-hot and never asserts in IDLE.
- Reset mid-operation abandons the current page. No ack is issued on reset exit until the IDLE selection.

Test Plan (NSRC=4, DWELL=10, DEB=3):
1. Reset asserted, src_valid=0 -> hex0..hex5=8'hBF, page=0, page_ack=0; outputs stay there after reset release.
2. src_valid=4'b0101, src0=24'h012345, src2=24'hABCDEF ->
   - page_ack=4'b0001 pulse, then hex5..hex0 = C0, F9, A4, B0, 99, 92.
   - 10 cycles later page=2, page_ack=4'b0100, hex5..hex0 = 88, 83, C6, A1, 86, 8E.
   - 10 cycles after that, wrap to page 0.
3. hold=1 on page 0 for 40 cycles -> page stays 0, hex0=8'h12. key_n low 2 cycles -> no advance. key_n low 5 cycles -> exactly one advance to page 2.
4. src_valid[2] cleared at dwell 4 on page 2 -> page=0 next edge with ack[0]. Then src_valid=0 -> IDLE, dashes, no ack.
5. Only src_valid[1] set, dwell expires -> page stays 1, no ack, hex unchanged.
6. Press event coincident with dwell expiry (src_valid=4'b1111, page 1) -> single advance to page 2, single ack. Then reset asserted mid-dwell -> outputs at reset values the same cycle, asynchronously.
